// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch mode controller: 1 Hz / 2 Hz enable strobes, input synchronize and debounce,
// and the RUN/PAUSED/ADJ state machine that steers the strobes into the counter chain.
module stopwatch_mode_ctrl #(
    parameter int ONEHZ_DIV = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_adj,
    input  logic       i_sel,
    input  logic       i_pause_btn,
    input  logic       i_clr_btn,
    output logic       o_cnt_en,
    output logic       o_adj_sec_en,
    output logic       o_adj_min_en,
    output logic       o_clr,
    output logic       o_blink,
    output logic [1:0] o_mode
);
    localparam int PW = $clog2(ONEHZ_DIV);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(ONEHZ_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(ONEHZ_DIV / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_PAUSED = 2'b01,
        S_ADJ    = 2'b10
    } state_t;

    // Input bit order: 0 adj, 1 sel, 2 pause, 3 clr
    logic [3:0]         w_raw;
    logic [3:0]         r_sync1, r_sync2, r_db, r_db_q;
    logic [3:0][DW-1:0] r_dbcnt;

    assign w_raw = {i_clr_btn, i_pause_btn, i_sel, i_adj};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_dbcnt <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int i = 0; i < 4; i++) begin
                // Any sample matching the accepted level restarts the stability count
                if (r_sync2[i] != r_db[i]) begin
                    if (r_dbcnt[i] == D_LAST) begin
                        r_db[i]    <= r_sync2[i];
                        r_dbcnt[i] <= '0;
                    end else begin
                        r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
                    end
                end else begin
                    r_dbcnt[i] <= '0;
                end
            end
        end
    end

    logic w_adj_rise, w_adj_fall, w_sel_s, w_pause, w_clr;
    assign w_adj_rise = r_db[0] & ~r_db_q[0];
    assign w_adj_fall = ~r_db[0] & r_db_q[0];
    assign w_sel_s    = r_db[1];
    assign w_pause    = r_db[2] & ~r_db_q[2];
    assign w_clr      = r_db[3] & ~r_db_q[3];

    logic [PW-1:0] r_pcnt, w_pcnt_nx;
    logic          w_tick1, w_tick2;
    assign w_tick1 = (r_pcnt == P_LAST);
    assign w_tick2 = w_tick1 | (r_pcnt == P_HALF);

    state_t r_state, r_ret, w_state_nx, w_ret_nx;
    logic   r_cnt_en, r_sec_en, r_min_en, r_clr, r_blink;
    logic   w_cnt_en_nx, w_sec_en_nx, w_min_en_nx, w_blink_nx;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_RUN;
            r_ret    <= S_RUN;
            r_pcnt   <= '0;
            r_cnt_en <= 1'b0;
            r_sec_en <= 1'b0;
            r_min_en <= 1'b0;
            r_clr    <= 1'b0;
            r_blink  <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_ret    <= w_ret_nx;
            r_pcnt   <= w_pcnt_nx;
            r_cnt_en <= w_cnt_en_nx;
            r_sec_en <= w_sec_en_nx;
            r_min_en <= w_min_en_nx;
            r_clr    <= w_clr;
            r_blink  <= w_blink_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ret_nx    = r_ret;
        w_pcnt_nx   = w_tick1 ? '0 : r_pcnt + PW'(1);
        w_cnt_en_nx = 1'b0;
        w_sec_en_nx = 1'b0;
        w_min_en_nx = 1'b0;
        w_blink_nx  = 1'b1;
        // A clear pulse suppresses every advance so the cleared time stays at zero
        case (r_state)
            S_RUN: begin
                w_cnt_en_nx = w_tick1 & ~w_clr;
                if (w_pause) w_state_nx = S_PAUSED;
            end
            S_PAUSED: begin
                if (w_pause) w_state_nx = S_RUN;
            end
            S_ADJ: begin
                w_blink_nx = r_blink;
                if (w_tick2 && !w_clr) begin
                    w_sec_en_nx = ~w_sel_s;
                    w_min_en_nx = w_sel_s;
                    w_blink_nx  = ~r_blink;
                end
                if (w_adj_fall) begin
                    w_state_nx = r_ret;
                    w_blink_nx = 1'b1;
                end
            end
            default: w_state_nx = S_RUN;
        endcase
        // ADJ entry overrides a same-cycle pause; ret keeps the pre-pause state
        if (w_adj_rise) begin
            w_state_nx = S_ADJ;
            w_ret_nx   = (r_state == S_ADJ) ? r_ret : r_state;
            w_blink_nx = 1'b1;
        end
        if (w_adj_rise || w_clr) w_pcnt_nx = '0;
    end

    assign o_cnt_en     = r_cnt_en;
    assign o_adj_sec_en = r_sec_en;
    assign o_adj_min_en = r_min_en;
    assign o_clr        = r_clr;
    assign o_blink      = r_blink;
    assign o_mode       = r_state;
endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
module tb_stopwatch_mode_ctrl;
    localparam int DIV = 8;
    localparam int DB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic adj = 1'b0, sel = 1'b0, pause_btn = 1'b0, clr_btn = 1'b0;
    logic cnt_en, adj_sec_en, adj_min_en, clr, blink;
    logic [1:0] mode;

    always #5 clk = ~clk;

    stopwatch_mode_ctrl #(.ONEHZ_DIV(DIV), .DB_CYCLES(DB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_adj(adj), .i_sel(sel),
        .i_pause_btn(pause_btn), .i_clr_btn(clr_btn),
        .o_cnt_en(cnt_en), .o_adj_sec_en(adj_sec_en), .o_adj_min_en(adj_min_en),
        .o_clr(clr), .o_blink(blink), .o_mode(mode)
    );

    typedef struct packed {
        logic       cnt_en;
        logic       sec;
        logic       min;
        logic       clr;
        logic       blink;
        logic [1:0] mode;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    bit [3:0] m_s1, m_s2, m_deb, m_debp, m_lastv;
    int       m_run[4];
    int       m_phase, m_mode, m_ret, m_nmode;
    bit       m_blink, m_nblink;
    bit       pr, cp, ar, af, m_sel, t1, t2;
    exp_t     e;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_deb = '0; m_debp = '0; m_lastv = '0;
                for (int i = 0; i < 4; i++) m_run[i] = 0;
                m_phase = 0; m_mode = 0; m_ret = 0; m_blink = 1'b1;
                e = '0;
                e.blink = 1'b1;
                expq.push_back(e);
            end else begin
                ar    = m_deb[0] & ~m_debp[0];
                af    = ~m_deb[0] & m_debp[0];
                m_sel = m_deb[1];
                pr    = m_deb[2] & ~m_debp[2];
                cp    = m_deb[3] & ~m_debp[3];
                t1    = (m_phase == DIV - 1);
                t2    = ((m_phase % (DIV / 2)) == DIV / 2 - 1);
                e = '0;
                e.clr    = cp;
                e.cnt_en = (m_mode == 0) && t1 && !cp;
                if (m_mode == 2 && t2 && !cp) begin
                    if (m_sel) e.min = 1'b1;
                    else       e.sec = 1'b1;
                end
                m_nmode  = m_mode;
                m_nblink = m_blink;
                if (ar) begin
                    if (m_mode != 2) m_ret = m_mode;
                    m_nmode  = 2;
                    m_nblink = 1'b1;
                end else if (m_mode == 2) begin
                    if (af) begin
                        m_nmode  = m_ret;
                        m_nblink = 1'b1;
                    end else if (t2 && !cp) begin
                        m_nblink = !m_blink;
                    end
                end else begin
                    m_nblink = 1'b1;
                    if (pr) m_nmode = 1 - m_mode;
                end
                m_phase = (ar || cp) ? 0 : (m_phase + 1) % DIV;
                m_mode  = m_nmode;
                m_blink = m_nblink;
                e.mode  = 2'(m_mode);
                e.blink = m_blink;
                m_debp = m_deb;
                for (int i = 0; i < 4; i++) begin
                    if (m_s2[i] == m_lastv[i]) m_run[i]++;
                    else begin
                        m_lastv[i] = m_s2[i];
                        m_run[i]   = 1;
                    end
                    if (m_run[i] >= DB && m_deb[i] != m_s2[i]) m_deb[i] = m_s2[i];
                end
                m_s2 = m_s1;
                m_s1 = {clr_btn, pause_btn, sel, adj};
                expq.push_back(e);
            end
        end
    end

    exp_t act, want;
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                want = expq.pop_front();
                act  = '{cnt_en, adj_sec_en, adj_min_en, clr, blink, mode};
                n_checks++;
                if (act === want) n_pass++;
                else $display("FAIL outputs cyc=%0d got cnt_en=%b sec=%b min=%b clr=%b blink=%b mode=%b exp cnt_en=%b sec=%b min=%b clr=%b blink=%b mode=%b",
                              cyc, act.cnt_en, act.sec, act.min, act.clr, act.blink, act.mode,
                              want.cnt_en, want.sec, want.min, want.clr, want.blink, want.mode);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_pause(input int hold);
        pause_btn = 1'b1; step(hold); pause_btn = 1'b0; step(12);
    endtask

    int r;
    int waited;
    bit seen;
    initial begin
        step(3);
        n_checks++;
        if (cnt_en === 1'b0 && adj_sec_en === 1'b0 && adj_min_en === 1'b0 &&
            clr === 1'b0 && blink === 1'b1 && mode === 2'b00) n_pass++;
        else $display("FAIL reset state cnt_en=%b sec=%b min=%b clr=%b blink=%b mode=%b",
                      cnt_en, adj_sec_en, adj_min_en, clr, blink, mode);
        rst_n = 1'b1;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 2 * DIV) begin
            step(1);
            waited++;
            if (cnt_en === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL timeout: no cnt_en pulse within %0d cycles of reset release", 2 * DIV);
        step(80 - waited);
        press_pause(10);
        step(20);
        press_pause(10);
        step(20);
        press_pause(3);
        step(10);
        press_pause(10);
        sel = 1'b1; adj = 1'b1; step(30);
        sel = 1'b0; step(20);
        clr_btn = 1'b1; step(8); clr_btn = 1'b0; step(14);
        adj = 1'b0; step(20);
        press_pause(10);
        adj = 1'b1; pause_btn = 1'b1; step(10); pause_btn = 1'b0; step(20);
        adj = 1'b0; step(20);
        pause_btn = 1'b1; clr_btn = 1'b1; step(10);
        pause_btn = 1'b0; clr_btn = 1'b0; step(20);
        pause_btn = 1'b1; step(3);
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        pause_btn = 1'b0; step(20);
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 39));
            if (r == 0) begin
                rst_n = 1'b0; step(1); rst_n = 1'b1;
            end else begin
                case (r % 4)
                    0: adj       = ~adj;
                    1: sel       = ~sel;
                    2: pause_btn = ~pause_btn;
                    default: clr_btn = ~clr_btn;
                endcase
            end
            step(int'($urandom_range(1, 14)));
        end
        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_mode_ctrl.md
# stopwatch_mode_ctrl

Mode controller for the stopwatch time-keeping path. It derives single-cycle 1 Hz and 2 Hz enable strobes from the system clock, debounces the front-panel switches and buttons, and runs the RUN/PAUSED/ADJ state machine. That state machine decides which strobe drives the counter chain (normal count or seconds/minutes adjust). It replaces a raw clock mux with one clock domain and clock enables, and it also supplies the blink control used by the display driver.

## Interface
- `ONEHZ_DIV`, 100_000_000, clk cycles per 1 Hz period; must be even and ≥ 4.
- `DB_CYCLES`, 1_000_000, consecutive stable synchronized cycles required to accept a change on any switch or button input; must be ≥ 1.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous reset, active-low.
- `adj`  in  1  raw adjust switch (async); 1 = adjust mode.
- `sel`  in  1  raw select switch (async); 0 = adjust seconds, 1 = adjust minutes.
- `pause_btn`  in  1  raw pause button (async); each press toggles run/pause.
- `clr_btn`  in  1  raw clear button (async); each press clears the time.
- `cnt_en`  out  1  1-cycle pulse; advance the seconds counter normally (carry handled downstream).
- `adj_sec_en`  out  1  1-cycle pulse; increment seconds without carry.
- `adj_min_en`  out  1  1-cycle pulse; increment minutes.
- `clr`  out  1  1-cycle pulse; clear all time digits.
- `blink`  out  1  display enable level for the selected field; 1 = show.
- `mode`  out  2  current state: 00 RUN, 01 PAUSED, 10 ADJ.

## Operation
- **Input conditioning:** all four raw inputs go through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized value has differed from it for `DB_CYCLES` consecutive cycles. Any glitch restarts the count.
  - Buttons produce a 1-cycle pulse on the debounced rising edge. A held button produces exactly one pulse.
  - `adj_s` and `sel_s` are debounced levels.
- **Prescaler:** counter `pcnt` runs 0..`ONEHZ_DIV`-1 and wraps to 0.
  - `tick1` fires when `pcnt` = `ONEHZ_DIV`-1.
  - `tick2` fires when `pcnt` = `ONEHZ_DIV`/2-1 or `pcnt` = `ONEHZ_DIV`-1.
- **FSM:**
  - RUN: `cnt_en` = `tick1`. A pause pulse moves to PAUSED.
  - PAUSED: no enables. A pause pulse moves to RUN.
  - Any state goes to ADJ when `adj_s` rises. On entry, the FSM saves the prior state (RUN or PAUSED) in `ret_state` and forces `pcnt` to 0.
  - ADJ: `cnt_en` = 0. On `tick2`, `adj_sec_en` pulses if `sel_s` = 0, otherwise `adj_min_en` pulses. Pause pulses are ignored. When `adj_s` falls, the FSM returns to `ret_state`.
- **Clear:** a clear pulse, in any state, raises `clr` for 1 cycle and forces `pcnt` to 0. The FSM state is unchanged. The cleared time must not advance in the same cycle, so `cnt_en`, `adj_sec_en` and `adj_min_en` are all 0 during the `clr` cycle.
- **Blink:**
  - In ADJ, `blink` toggles on every `tick2`.
  - In RUN or PAUSED, `blink` = 1.
  - `blink` is forced to 1 on ADJ entry and on ADJ exit.
- **Simultaneous events:**
  - Clear and pause in the same cycle: both take effect.
  - `adj_s` rise and pause pulse in the same cycle: ADJ wins, and `ret_state` captures the state before the pause is applied.
  - `sel_s` change during ADJ: takes effect on the next `tick2`. No pulse is lost or duplicated.

## Timing
- Reset: `mode` = RUN, `ret_state` = RUN, `pcnt` = 0, `blink` = 1. `cnt_en`, `adj_sec_en`, `adj_min_en` and `clr` = 0. Synchronizer and debouncer state = 0. Debounce counters = 0.
- Reset asserted mid-operation returns everything to the reset values at the next edge and drops any pending debounce.
- All outputs are registered, 1 cycle after the qualifying internal event.
- Raw button rise to output effect (`clr` pulse or `mode` change) = 2 + `DB_CYCLES` + 1 cycles when the input is clean.
- In RUN with no other events, `cnt_en` pulses exactly every `ONEHZ_DIV` cycles.
- In ADJ with no other events, the adjust pulses come exactly every `ONEHZ_DIV`/2 cycles, starting `ONEHZ_DIV`/2 cycles after ADJ entry.

## Test plan
All scenarios use `ONEHZ_DIV` = 8 and `DB_CYCLES` = 4.
- **Reset and RUN:** release `rst_n` → `mode` = 00, `blink` = 1; over 80 cycles `cnt_en` pulses 10 times, exactly 8 cycles apart.
- **Pause toggle:** press `pause_btn` clean for 10 cycles → `mode` = 01 at cycle 7 after the press and `cnt_en` stops. A second press → `mode` = 00 and `cnt_en` resumes. A 3-cycle glitch press → no change.
- **Adjust:** from PAUSED, set `adj` = 1 with `sel` = 1 → `mode` = 10; `adj_min_en` pulses every 4 cycles, `blink` toggles with each pulse. Flip `sel` to 0 → pulses move to `adj_sec_en`. Drop `adj` → `mode` = 01 and `blink` = 1.
- **Clear during adjust:** assert `clr_btn` while in ADJ → one `clr` pulse with no adjust pulse in that cycle; the next adjust pulse comes 4 cycles after `clr`; `mode` stays 10.
- **Simultaneous:** in RUN, `adj` rise and pause press debounced in the same cycle → `mode` = 10; after `adj` falls, `mode` = 00. Pause and clear in the same cycle → `clr` pulses and `mode` = 01.
- **Reset mid-debounce:** hold `pause_btn` for 3 cycles, pulse `rst_n` low for 1 cycle → no pause pulse, and all outputs at their reset values.
